dfii_init_bist: RTL and testbench

Synthesisable Wishbone bus master that replaces the hand-written DDR3 bring-up sequence with hardware. It sits beside the DFII CSR bank and the DRAM port on the SoC Wishbone interconnect. After `start` it performs the DDR3 reset, mode-register and ZQ calibration sequence through the DFII registers and hands control to the controller. It then runs a parametrised write/read-back self-test over a DRAM window and reports pass, fail or timeout.

---
 rtl/dfii_init_bist.sv | 146 ++++++++++++++
 tb/tb_dfii_init_bist.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dfii_init_bist.sv
// dfii_init_bist: Wishbone master that brings up DDR3 through the DFII CSRs,
// then writes and reads back a seeded pattern window, reporting pass/fail/timeout.
module dfii_init_bist #(
    parameter logic [29:0] CSR_BASE       = 30'h2400,
    parameter logic [29:0] MEM_BASE       = 30'h04000000,
    parameter logic [15:0] MR0            = 16'h0220,
    parameter logic [15:0] MR1            = 16'h0006,
    parameter logic [15:0] MR2            = 16'h0200,
    parameter logic [15:0] MR3            = 16'h0000,
    parameter int          TDLLK_CYCLES   = 600,
    parameter int          TZQINIT_CYCLES = 600,
    parameter int          SETTLE_CYCLES  = 200,
    parameter int          TEST_WORDS     = 4,
    parameter logic [31:0] SEED           = 32'hFACECA8C,
    parameter int          ACK_TIMEOUT    = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [29:0] fail_addr,
    output logic [31:0] fail_data,
    output logic [29:0] wb_adr,
    output logic [31:0] wb_dat_w,
    input  logic [31:0] wb_dat_r,
    output logic [3:0]  wb_sel,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    input  logic        wb_ack
);
    typedef enum logic [2:0] {IDLE, BUS, WAIT, TEST_WR, TEST_RD, FINISH} state_t;
    localparam logic [4:0]  STEPS     = 5'd28;
    localparam logic [15:0] LAST_WORD = 16'(TEST_WORDS - 1);
    state_t state, state_n;
    logic [4:0]  step;
    logic [15:0] idx;
    logic [31:0] cnt, tmo, rom_dat, pat;
    logic [35:0] rom;
    logic [2:0]  rom_off;
    logic        rom_dly, rd, start_q, on_bus, mis, last, tmo_hit;
    function automatic logic [35:0] wr(input logic [2:0] off, input logic [31:0] dat);
        return {1'b0, off, dat};
    endfunction
    // Step ROM: {is_delay, CSR offset, data or delay length}
    always_comb begin
        case (step)
            5'd0:  rom = wr(3'd3, 32'h0);
            5'd1:  rom = wr(3'd4, 32'h0);
            5'd2:  rom = wr(3'd0, 32'h0C);
            5'd3:  rom = wr(3'd0, 32'h0E);
            5'd4:  rom = wr(3'd3, {16'h0, MR2});
            5'd5:  rom = wr(3'd4, 32'h2);
            5'd8:  rom = wr(3'd3, {16'h0, MR3});
            5'd9:  rom = wr(3'd4, 32'h3);
            5'd12: rom = wr(3'd3, {16'h0, MR1});
            5'd13: rom = wr(3'd4, 32'h1);
            5'd16: rom = wr(3'd3, {16'h0, MR0 | 16'h0100});
            5'd17: rom = wr(3'd4, 32'h0);
            5'd6, 5'd10, 5'd14, 5'd18: rom = wr(3'd1, 32'h0F);
            5'd7, 5'd11, 5'd15, 5'd19: rom = wr(3'd2, 32'h1);
            5'd20: rom = {1'b1, 3'd0, 32'(TDLLK_CYCLES)};
            5'd21: rom = wr(3'd3, 32'h400);
            5'd22: rom = wr(3'd4, 32'h0);
            5'd23: rom = wr(3'd1, 32'h03);
            5'd24: rom = wr(3'd2, 32'h1);
            5'd25: rom = {1'b1, 3'd0, 32'(TZQINIT_CYCLES)};
            5'd26: rom = wr(3'd0, 32'h01);
            default: rom = {1'b1, 3'd0, 32'(SETTLE_CYCLES)};
        endcase
    end
    assign {rom_dly, rom_off, rom_dat} = rom;
    assign pat      = {idx, ~idx} ^ SEED;
    assign on_bus   = state inside {BUS, TEST_WR, TEST_RD};
    assign busy     = on_bus || state == WAIT;
    assign wb_cyc   = on_bus;
    assign wb_stb   = on_bus;
    assign wb_sel   = on_bus ? 4'hF : 4'h0;
    assign wb_we    = state == BUS || state == TEST_WR;
    assign wb_adr   = state == BUS ? CSR_BASE + {27'd0, rom_off} : on_bus ? MEM_BASE + {14'd0, idx} : 30'd0;
    assign wb_dat_w = state == BUS ? rom_dat : state == TEST_WR ? pat : 32'd0;
    assign mis      = state == TEST_RD && wb_dat_r != pat;
    assign last     = idx == LAST_WORD;
    assign tmo_hit  = on_bus && !wb_ack && tmo == 32'(ACK_TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:         state_n = start && !start_q ? BUS : IDLE;
            BUS, TEST_WR: state_n = tmo_hit ? FINISH : wb_ack ? WAIT : state;
            TEST_RD:      state_n = tmo_hit ? FINISH : !wb_ack ? TEST_RD : (mis || last) ? FINISH : WAIT;
            WAIT:         state_n = cnt != 0 ? WAIT : step < STEPS ? (rom_dly ? WAIT : BUS) :
                                    TEST_WORDS == 0 ? FINISH : rd ? TEST_RD : TEST_WR;
            FINISH:       state_n = IDLE;
            default:      state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            {step, idx, cnt, tmo, rd, start_q} <= '0;
            {done, error, err_code, fail_addr, fail_data} <= '0;
        end else begin
            start_q <= start;
            tmo <= on_bus && !wb_ack ? tmo + 32'd1 : 32'd0;
            if (state == IDLE && state_n == BUS) begin
                {step, idx, cnt, rd} <= '0;
                {done, error, err_code, fail_addr, fail_data} <= '0;
            end
            if (state == BUS && wb_ack) step <= step + 5'd1;
            if (state == TEST_WR && wb_ack) begin
                idx <= last ? 16'd0 : idx + 16'd1;
                rd <= rd | last;
            end
            if (state == TEST_RD && wb_ack && !mis) idx <= idx + 16'd1;
            if (state == WAIT && cnt != 0) cnt <= cnt - 32'd1;
            // Entering a delay step: this gap cycle plus rom_dat counted cycles
            if (state == WAIT && cnt == 0 && step < STEPS && rom_dly) begin
                step <= step + 5'd1;
                cnt <= rom_dat == 0 ? 32'd0 : rom_dat - 32'd1;
            end
            if (tmo_hit) begin
                err_code <= 2'd1;
                fail_addr <= wb_adr;
                fail_data <= 32'd0;
            end else if (mis && wb_ack) begin
                err_code <= 2'd2;
                fail_addr <= wb_adr;
                fail_data <= wb_dat_r;
            end
            if (state_n == FINISH && !tmo_hit) begin
                done <= 1'b1;
                error <= mis && wb_ack;
            end
            if (state == FINISH) begin
                done <= 1'b1;
                error <= err_code != 0;
            end
        end
    end
endmodule

// File: tb/tb_dfii_init_bist.sv
// tb_dfii_init_bist: randomized Wishbone slave plus transaction-level reference
// of the bring-up/self-test sequence, checked with immediate assertions.
module tb_dfii_init_bist;
    localparam logic [29:0] CSR = 30'h2400;
    localparam logic [29:0] MEM = 30'h04000000;
    localparam logic [31:0] SEED = 32'hFACECA8C;
    localparam int TDLLK = 20, TZQ = 15, SETTLE = 10, WORDS = 4, TMO = 15;
    logic        clk = 0, rst = 1, start = 0;
    logic        busy, done, error, wb_cyc, wb_stb, wb_we, wb_ack = 0;
    logic [1:0]  err_code;
    logic [29:0] fail_addr, wb_adr;
    logic [31:0] fail_data, wb_dat_w, wb_dat_r = 0;
    logic [3:0]  wb_sel;
    typedef struct {logic [29:0] adr; logic we; logic [31:0] dat; bit ok; int gap; int t0; int ta;} txn_t;
    txn_t exp_q[$], log_q[$];
    logic [31:0] mem [logic [29:0]];
    int vectors = 0, miscompares = 0;
    int cycle = 0, lat_mode = 0, bad_idx = -1, hi_run = 0, last_hi = 0, t_drop = 0;
    logic [31:0] bad_val = 0;
    bit noack = 0;

    dfii_init_bist #(.CSR_BASE(CSR), .MEM_BASE(MEM), .TDLLK_CYCLES(TDLLK), .TZQINIT_CYCLES(TZQ),
                     .SETTLE_CYCLES(SETTLE), .TEST_WORDS(WORDS), .SEED(SEED), .ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .fail_addr(fail_addr), .fail_data(fail_data), .wb_adr(wb_adr),
        .wb_dat_w(wb_dat_w), .wb_dat_r(wb_dat_r), .wb_sel(wb_sel), .wb_cyc(wb_cyc),
        .wb_stb(wb_stb), .wb_we(wb_we), .wb_ack(wb_ack));

    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cycle++;
    end

    function automatic logic [31:0] pat(input int i);
        return 32'(i * 65536 + (65535 - i)) ^ SEED;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic add(input logic [29:0] a, input logic we, input logic [31:0] d, input int g);
        txn_t t;
        t.adr = a; t.we = we; t.dat = d; t.ok = 1; t.gap = g; t.t0 = 0; t.ta = 0;
        exp_q.push_back(t);
    endtask

    // Expected bus traffic derived from the bring-up recipe and the test pattern
    task automatic build_exp();
        logic [15:0] mr [4];
        int ba [4];
        mr = '{16'h0200, 16'h0000, 16'h0006, 16'h0320};
        ba = '{2, 3, 1, 0};
        exp_q.delete();
        add(CSR + 3, 1, 0, 0); add(CSR + 4, 1, 0, 0); add(CSR, 1, 32'h0C, 0); add(CSR, 1, 32'h0E, 0);
        for (int k = 0; k < 4; k++) begin
            add(CSR + 3, 1, {16'h0, mr[k]}, 0); add(CSR + 4, 1, 32'(ba[k]), 0);
            add(CSR + 1, 1, 32'h0F, 0); add(CSR + 2, 1, 1, 0);
        end
        add(CSR + 3, 1, 32'h400, TDLLK); add(CSR + 4, 1, 0, 0); add(CSR + 1, 1, 3, 0); add(CSR + 2, 1, 1, 0);
        add(CSR, 1, 1, TZQ);
        for (int i = 0; i < WORDS; i++) add(MEM + 30'(i), 1, pat(i), i == 0 ? SETTLE : 0);
        for (int i = 0; i < WORDS; i++) add(MEM + 30'(i), 0, 0, 0);
    endtask

    // Wishbone slave: DRAM-like memory, programmable ack latency, optional corruption/no-ack
    initial begin : slave
        bit active;
        int n, lat;
        txn_t t;
        active = 0; n = 0; lat = 0;
        forever begin
            @(negedge clk);
            if (wb_cyc) hi_run++;
            else if (hi_run > 0) begin
                last_hi = hi_run; t_drop = cycle; hi_run = 0;
            end
            if (wb_ack || !wb_cyc) begin
                wb_ack = 0; active = 0;
            end else begin
                if (!active) begin
                    active = 1; n = 0;
                    t.adr = wb_adr; t.we = wb_we; t.dat = wb_we ? wb_dat_w : 32'h0;
                    t.ok = 1; t.gap = 0; t.t0 = cycle; t.ta = 0;
                    lat = lat_mode < 0 ? int'($urandom_range(3, 0)) : lat_mode;
                end else n++;
                if (wb_adr != t.adr || wb_we != t.we || (t.we && wb_dat_w != t.dat) || wb_sel != 4'hF || !wb_stb)
                    t.ok = 0;
                if (n >= lat && !(noack && wb_we && wb_adr == CSR && wb_dat_w == 32'h0E)) begin
                    wb_ack = 1; t.ta = cycle;
                    if (wb_we) mem[wb_adr] = wb_dat_w;
                    wb_dat_r = wb_we ? 32'h0 : int'(wb_adr - MEM) == bad_idx ? bad_val :
                               mem.exists(wb_adr) ? mem[wb_adr] : 32'h0;
                    log_q.push_back(t);
                end else wb_dat_r = $urandom;
            end
        end
    end

    task automatic run(input int lm, input int bad, input logic [31:0] bv, input bit hold,
                       output int t_acc, output int t_done);
        lat_mode = lm; bad_idx = bad; bad_val = bv;
        log_q.delete(); mem.delete();
        @(negedge clk);
        start = 1; t_acc = cycle;
        @(negedge clk);
        if (!hold) start = 0;
        chk("start_accept", {busy, wb_cyc, wb_stb, done, error}, 5'b11100);
        t_done = -1;
        for (int k = 0; k < 3000 && t_done < 0; k++) begin
            if (done) t_done = cycle;
            else @(negedge clk);
        end
        chk("done_within_budget", t_done >= 0, 1);
        repeat (5) @(negedge clk);
    endtask

    task automatic check_result(input int n, input logic [1:0] ec, input logic [29:0] fa,
                                input logic [31:0] fd, input int t_acc, input int t_done);
        int prev;
        chk("txn_count", log_q.size(), n);
        for (int j = 0; j < n && j < log_q.size(); j++) begin
            chk($sformatf("txn%0d", j), {log_q[j].adr, log_q[j].we, log_q[j].dat, log_q[j].ok},
                {exp_q[j].adr, exp_q[j].we, exp_q[j].dat, 1'b1});
            if (j == 0) prev = t_acc;
            else prev = log_q[j-1].ta;
            chk($sformatf("gap%0d", j), log_q[j].t0 - prev, j == 0 ? 1 : 2 + exp_q[j].gap);
        end
        chk("status", {done, error, busy, err_code}, {1'b1, ec != 0, 1'b0, ec});
        chk("fail_addr", fail_addr, fa);
        chk("fail_data", fail_data, fd);
        if (ec != 1 && log_q.size() > 0) chk("done_latency", t_done - log_q[log_q.size()-1].ta, 1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, {busy, done, error, err_code, wb_sel, wb_cyc, wb_stb, wb_we}, 0);
        chk({tag, "_adr"}, wb_adr, 0);
        chk({tag, "_dat"}, wb_dat_w, 0);
        chk({tag, "_fail"}, {fail_addr, fail_data}, 0);
    endtask

    initial begin
        int ta, td, k;
        logic [31:0] bv;
        build_exp();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 0;
        run(0, -1, 0, 0, ta, td);
        check_result(33, 0, 0, 0, ta, td);
        run(3, -1, 0, 0, ta, td);
        check_result(33, 0, 0, 0, ta, td);
        run(-1, -1, 0, 0, ta, td);
        check_result(33, 0, 0, 0, ta, td);
        run(0, 2, 32'hDEADBEEF, 0, ta, td);
        check_result(32, 2, MEM + 2, 32'hDEADBEEF, ta, td);
        k = int'($urandom_range(3, 0));
        bv = $urandom;
        if (bv == pat(k)) bv = ~bv;
        run(-1, k, bv, 0, ta, td);
        check_result(30 + k, 2, MEM + 30'(k), bv, ta, td);
        noack = 1;
        run(0, -1, 0, 0, ta, td);
        noack = 0;
        check_result(3, 1, CSR, 0, ta, td);
        chk("tmo_cyc_high", last_hi, TMO);
        chk("tmo_done_latency", td - t_drop, 1);
        lat_mode = 3;
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        k = 0;
        while (k < 2000 && !(wb_cyc && wb_adr == CSR + 3 && wb_dat_w == 32'h6)) begin
            @(negedge clk);
            k++;
        end
        chk("mr1_reached", k < 2000, 1);
        rst = 1;
        @(negedge clk);
        check_zero("midrst");
        rst = 0;
        run(-1, -1, 0, 0, ta, td);
        check_result(33, 0, 0, 0, ta, td);
        run(0, -1, 0, 1, ta, td);
        check_result(33, 0, 0, 0, ta, td);
        repeat (40) @(negedge clk);
        chk("hold_no_rerun", {log_q.size() == 33, busy, done}, 3'b101);
        start = 0;
        run(0, -1, 0, 0, ta, td);
        check_result(33, 0, 0, 0, ta, td);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
